// File: rtl/mmio_timer_pwm.sv
// Memory-mapped micros/millis timebase, microsecond compare timer with level interrupt,
// and shadowed multi-channel PWM, decoded in the 0xFFFFFF00..0xFFFFFFFF window.
module mmio_timer_pwm #(
    parameter int CLK_HZ   = 12000000,
    parameter int NUM_PWM  = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_mem,
    input  logic [2:0]          funct3,
    input  logic [31:0]         write_address,
    input  logic [31:0]         write_data,
    input  logic [31:0]         read_address,
    output logic [31:0]         read_data,
    output logic [NUM_PWM-1:0]  pwm_out,
    output logic                irq_timer
);

    localparam int US_DIV = CLK_HZ / 1000000;
    localparam int MS_DIV = CLK_HZ / 1000;
    localparam int US_W   = $clog2(US_DIV);
    localparam int MS_W   = $clog2(MS_DIV);
    localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);

    localparam logic [5:0] W_MICROS  = 6'd0;
    localparam logic [5:0] W_MILLIS  = 6'd1;
    localparam logic [5:0] W_TIMECMP = 6'd2;
    localparam logic [5:0] W_CTRL    = 6'd3;

    logic [US_W-1:0]     div_us;
    logic [MS_W-1:0]     div_ms;
    logic [31:0]         micros;
    logic [31:0]         millis;
    logic [31:0]         timecmp;
    logic                irq_en;
    logic                pending;
    logic                match_q;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_shadow [NUM_PWM];
    logic [PWM_BITS-1:0] duty_active [NUM_PWM];

    logic        wr_hit;
    logic [5:0]  wr_word;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] timecmp_merged;
    logic [31:0] ctrl_merged;
    logic        pending_clr;
    logic        us_tc;
    logic        ms_tc;

    logic        rd_hit;
    logic [5:0]  rd_word;
    logic [31:0] rd_sel;
    logic [31:0] rd_q;
    logic [1:0]  rd_lo;
    logic [2:0]  rd_f3;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] mask,
                                               input logic [31:0] data);
        return (old_val & ~mask) | (data & mask);
    endfunction

    assign wr_hit  = write_mem && (write_address[31:8] == 24'hFFFFFF);
    assign wr_word = write_address[7:2];
    assign us_tc   = (div_us == US_LAST);
    assign ms_tc   = (div_ms == MS_LAST);

    // Store data arrives right-aligned; replicate it across lanes and let the mask pick.
    always_comb begin
        lane_mask = 32'h0;
        lane_data = 32'h0;
        if (funct3[1]) begin
            lane_mask = 32'hFFFFFFFF;
            lane_data = write_data;
        end else if (funct3[0]) begin
            lane_mask = write_address[1] ? 32'hFFFF0000 : 32'h0000FFFF;
            lane_data = {2{write_data[15:0]}};
        end else begin
            lane_mask = 32'h000000FF << {write_address[1:0], 3'b000};
            lane_data = {4{write_data[7:0]}};
        end
    end

    assign timecmp_merged = lane_merge(timecmp, lane_mask, lane_data);
    assign ctrl_merged    = lane_merge({30'h0, pending, irq_en}, lane_mask, lane_data);
    assign pending_clr    = wr_hit && (wr_word == W_CTRL) && lane_mask[1] && lane_data[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_us  <= '0;
            div_ms  <= '0;
            micros  <= 32'h0;
            millis  <= 32'h0;
            timecmp <= 32'hFFFFFFFF;
            irq_en  <= 1'b0;
            pending <= 1'b0;
            match_q <= 1'b0;
        end else begin
            if (us_tc) begin
                div_us <= '0;
                micros <= micros + 32'd1;
            end else begin
                div_us <= div_us + US_W'(1);
            end
            if (ms_tc) begin
                div_ms <= '0;
                millis <= millis + 32'd1;
            end else begin
                div_ms <= div_ms + MS_W'(1);
            end
            // Compared against the pre-write timecmp; equality also catches the 2^32 wrap.
            match_q <= us_tc && ((micros + 32'd1) == timecmp);
            if (wr_hit && wr_word == W_TIMECMP) begin
                timecmp <= timecmp_merged;
            end
            if (wr_hit && wr_word == W_CTRL) begin
                irq_en <= ctrl_merged[0];
            end
            if (match_q) begin
                pending <= 1'b1;
            end else if (pending_clr) begin
                pending <= 1'b0;
            end
        end
    end

    assign irq_timer = pending & irq_en;

    // Active duty is reloaded only as cnt wraps, so a period is never cut short.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pwm_out <= '0;
            for (int n = 0; n < NUM_PWM; n++) begin
                duty_shadow[n] <= '0;
                duty_active[n] <= '0;
            end
        end else begin
            cnt <= cnt + PWM_BITS'(1);
            for (int n = 0; n < NUM_PWM; n++) begin
                if (wr_hit && wr_word == 6'(n + 4)) begin
                    duty_shadow[n] <= PWM_BITS'(lane_merge(32'(duty_shadow[n]), lane_mask, lane_data));
                end
                if (cnt == '1) begin
                    duty_active[n] <= duty_shadow[n];
                end
                pwm_out[n] <= (cnt < duty_active[n]);
            end
        end
    end

    assign rd_hit  = (read_address[31:8] == 24'hFFFFFF);
    assign rd_word = read_address[7:2];

    always_comb begin
        rd_sel = 32'h0;
        if (rd_hit) begin
            case (rd_word)
                W_MICROS:  rd_sel = micros;
                W_MILLIS:  rd_sel = millis;
                W_TIMECMP: rd_sel = timecmp;
                W_CTRL:    rd_sel = {30'h0, pending, irq_en};
                default: begin
                    for (int n = 0; n < NUM_PWM; n++) begin
                        if (rd_word == 6'(n + 4)) begin
                            rd_sel = 32'(duty_shadow[n]);
                        end
                    end
                end
            endcase
        end
    end

    // Falling-edge capture matches the RAM, so a same-cycle write is already visible.
    always_ff @(negedge clk) begin
        if (reset) begin
            rd_q  <= 32'h0;
            rd_lo <= 2'b00;
            rd_f3 <= 3'b000;
        end else begin
            rd_q  <= rd_sel;
            rd_lo <= read_address[1:0];
            rd_f3 <= funct3;
        end
    end

    assign rd_half = rd_lo[1] ? rd_q[31:16] : rd_q[15:0];
    assign rd_byte = rd_q[{rd_lo, 3'b000} +: 8];

    always_comb begin
        read_data = rd_q;
        if (!rd_f3[1]) begin
            if (rd_f3[0]) begin
                read_data = rd_f3[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end else begin
                read_data = rd_f3[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_pwm.sv
// Self-checking bench for mmio_timer_pwm: one 8-bit PWM instance for timers/PWM and a
// 16-bit PWM instance for wide duty load/store checks, sharing the bus inputs.
module tb_mmio_timer_pwm;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;
    logic [31:0] read_data16;
    logic [3:0]  pwm_out;
    logic [1:0]  pwm_out16;
    logic        irq_timer;
    logic        irq_timer16;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    mmio_timer_pwm #(.CLK_HZ(12000000), .NUM_PWM(4), .PWM_BITS(8)) dut (
        .clk(clk), .reset(reset), .write_mem(write_mem), .funct3(funct3),
        .write_address(write_address), .write_data(write_data),
        .read_address(read_address), .read_data(read_data),
        .pwm_out(pwm_out), .irq_timer(irq_timer)
    );

    mmio_timer_pwm #(.CLK_HZ(12000000), .NUM_PWM(2), .PWM_BITS(16)) dut16 (
        .clk(clk), .reset(reset), .write_mem(write_mem), .funct3(funct3),
        .write_address(write_address), .write_data(write_data),
        .read_address(read_address), .read_data(read_data16),
        .pwm_out(pwm_out16), .irq_timer(irq_timer16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        write_mem = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        write_address = addr;
        write_data    = data;
        funct3        = f3;
        write_mem     = 1'b1;
        tick();
        write_mem     = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [2:0] f3, input bit wide,
                            input logic [31:0] exp, input string tag);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        read_address = addr;
        funct3       = f3;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
        e = sb_q.pop_front();
        check_val(e.tag, wide ? read_data16 : read_data, e.exp);
    endtask

    task automatic wait_edge(input int k);
        int guard = 0;
        while (edge_n < k && guard < 50000) begin
            tick();
            guard++;
        end
        if (edge_n != k) check_val("sync_edge", edge_n, k);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_pre [4];
        int hi_p1  [4];
        int hi_p2  [4];
        int first_hi;

        reset = 1'b1; write_mem = 1'b0; funct3 = 3'b0;
        write_address = 32'h0; write_data = 32'h0; read_address = 32'h0;

        // Reset state
        tick();
        check_val("rst_pwm", 32'(pwm_out), 32'h0);
        check_val("rst_irq", 32'(irq_timer), 32'h0);
        check_val("rst_pwm16", 32'(pwm_out16), 32'h0);
        check_val("rst_irq16", 32'(irq_timer16), 32'h0);
        do_reset();
        bus_read(32'hFFFFFF00, LW, 0, 32'h0, "rst_micros");
        bus_read(32'hFFFFFF04, LW, 0, 32'h0, "rst_millis");
        bus_read(32'hFFFFFF08, LW, 0, 32'hFFFFFFFF, "rst_timecmp");
        bus_read(32'hFFFFFF0C, LW, 0, 32'h0, "rst_ctrl");
        for (int n = 0; n < 4; n++) begin
            bus_read(32'hFFFFFF10 + 32'(4 * n), LW, 0, 32'h0, $sformatf("rst_duty%0d", n));
        end

        // Timebase
        do_reset();
        wait_edge(24000);
        bus_read(32'hFFFFFF00, LW, 0, 32'd2000, "tb_micros");
        bus_read(32'hFFFFFF04, LW, 0, 32'd2, "tb_millis");

        // Compare interrupt
        do_reset();
        bus_write(32'hFFFFFF08, 32'd5, LW);
        bus_write(32'hFFFFFF0C, 32'd1, LW);
        wait_edge(60);
        check_val("irq_before", 32'(irq_timer), 32'h0);
        bus_read(32'hFFFFFF00, LW, 0, 32'd5, "cmp_micros");
        tick();
        check_val("irq_rise", 32'(irq_timer), 32'h1);
        bus_write(32'hFFFFFF0C, 32'd3, LW);
        check_val("irq_clear", 32'(irq_timer), 32'h0);
        bus_read(32'hFFFFFF0C, LW, 0, 32'h1, "ctrl_en_kept");
        bus_write(32'hFFFFFF08, 32'd8, LW);
        wait_edge(96);
        check_val("irq_pre8", 32'(irq_timer), 32'h0);
        bus_write(32'hFFFFFF0C, 32'd3, LW);
        check_val("set_wins_irq", 32'(irq_timer), 32'h1);
        bus_read(32'hFFFFFF0C, LW, 0, 32'h3, "set_wins_ctrl");
        bus_write(32'hFFFFFF0E, 32'h0000FFFF, LH);
        bus_read(32'hFFFFFF0C, LW, 0, 32'h3, "ctrl_upper_half");
        bus_write(32'hFFFFFF0C, 32'h00000003, LB);
        bus_read(32'hFFFFFF0C, LW, 0, 32'h1, "ctrl_byte_clr");

        // Timebase wrap
        do_reset();
        bus_write(32'hFFFFFF08, 32'd0, LW);
        bus_write(32'hFFFFFF0C, 32'd1, LW);
        force dut.micros = 32'hFFFFFFFE;
        tick();
        release dut.micros;
        wait_edge(12);
        bus_read(32'hFFFFFF00, LW, 0, 32'hFFFFFFFF, "wrap_micros_ff");
        check_val("wrap_irq_early", 32'(irq_timer), 32'h0);
        wait_edge(24);
        check_val("wrap_irq_pre", 32'(irq_timer), 32'h0);
        tick();
        check_val("wrap_irq", 32'(irq_timer), 32'h1);
        bus_read(32'hFFFFFF00, LW, 0, 32'h0, "wrap_micros_0");

        // PWM duty and shadowing
        do_reset();
        wait_edge(97);
        bus_write(32'hFFFFFF1C, 32'd128, LW);
        bus_write(32'hFFFFFF10, 32'd0, LW);
        bus_write(32'hFFFFFF14, 32'd255, LW);
        bus_write(32'hFFFFFF18, 32'd64, LW);
        for (int c = 0; c < 4; c++) begin
            hi_pre[c] = 0; hi_p1[c] = 0; hi_p2[c] = 0;
        end
        first_hi = 0;
        for (int k = 102; k <= 768; k++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                if (pwm_out[c]) begin
                    if (k <= 256)      hi_pre[c]++;
                    else if (k <= 512) hi_p1[c]++;
                    else               hi_p2[c]++;
                end
            end
            if (pwm_out[2] && first_hi == 0) first_hi = k;
        end
        for (int c = 0; c < 4; c++) begin
            check_val($sformatf("pwm_pre_ch%0d", c), 32'(hi_pre[c]), 32'h0);
        end
        check_val("pwm_p1_ch0", 32'(hi_p1[0]), 32'd0);
        check_val("pwm_p1_ch1", 32'(hi_p1[1]), 32'd255);
        check_val("pwm_p1_ch2", 32'(hi_p1[2]), 32'd64);
        check_val("pwm_p1_ch3", 32'(hi_p1[3]), 32'd128);
        check_val("pwm_p2_ch2", 32'(hi_p2[2]), 32'd64);
        check_val("pwm_p2_ch1", 32'(hi_p2[1]), 32'd255);
        check_val("pwm_first_hi", 32'(first_hi), 32'd257);
        bus_read(32'hFFFFFF18, LW, 0, 32'd64, "duty2_shadow");

        // Loads, stores and unmapped accesses
        do_reset();
        bus_write(32'hFFFFFF11, 32'h00000080, LB);
        bus_read(32'hFFFFFF11, LB, 0, 32'h0, "lb_duty0_w8");
        bus_read(32'hFFFFFF11, LB, 1, 32'hFFFFFF80, "lb_duty0_w16");
        bus_read(32'hFFFFFF11, LBU, 1, 32'h00000080, "lbu_duty0_w16");
        bus_write(32'hFFFFFF14, 32'h00008000, LW);
        bus_read(32'hFFFFFF14, LW, 0, 32'h0, "lw_duty1_w8");
        bus_read(32'hFFFFFF14, LW, 1, 32'h00008000, "lw_duty1_w16");
        bus_write(32'hFFFFFF09, 32'h00000080, LB);
        bus_write(32'hFFFFFF0A, 32'h00008001, LH);
        bus_read(32'hFFFFFF08, LW, 0, 32'h800180FF, "lw_timecmp");
        bus_read(32'hFFFFFF09, LB, 0, 32'hFFFFFF80, "lb_timecmp");
        bus_read(32'hFFFFFF09, LBU, 0, 32'h00000080, "lbu_timecmp");
        bus_read(32'hFFFFFF0A, LH, 0, 32'hFFFF8001, "lh_timecmp");
        bus_read(32'hFFFFFF0A, LHU, 0, 32'h00008001, "lhu_timecmp");
        bus_read(32'hFFFFFF08, LB, 0, 32'hFFFFFFFF, "lb_timecmp_b0");
        bus_read(32'hFFFFFF08, LBU, 0, 32'h000000FF, "lbu_timecmp_b0");
        bus_write(32'hFFFFFFF0, 32'hDEADBEEF, LW);
        bus_read(32'hFFFFFFF0, LW, 0, 32'h0, "unmapped_f0");
        bus_write(32'hFFFFFF20, 32'h00000055, LW);
        bus_read(32'hFFFFFF20, LW, 0, 32'h0, "unmapped_duty4");
        bus_write(32'hFFFFFF04, 32'h00001234, LW);
        bus_read(32'hFFFFFF04, LW, 0, 32'h0, "ro_millis");
        bus_write(32'h00001008, 32'h00000007, LW);
        bus_read(32'hFFFFFF08, LW, 0, 32'h800180FF, "outside_write");
        bus_read(32'h00001008, LW, 0, 32'h0, "outside_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
